// File: rtl/ivs_dma_wr_inf_if.sv
// ---------------------------------------------------------------------------
// ivs_dma_wr_inf_if -- AXI-style write channel bundle (AW / W / B) between
// the DMA write arbiter and the memory fabric.
//   master : driven by the DMA (address, data, bready)
//   slave  : driven by the fabric (awready, wready, bvalid, bid, bresp)
// Parameter BDWD sets the data width; wstrb is BDWD/8 bits.
// ---------------------------------------------------------------------------
interface ivs_dma_wr_inf_if #(
    parameter int BDWD = 128
);
    logic                awvalid;
    logic                awready;
    logic [3:0]          awid;
    logic [31:0]         awaddr;
    logic [5:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                wvalid;
    logic                wready;
    logic [BDWD-1:0]     wdata;
    logic [BDWD/8-1:0]   wstrb;
    logic                wlast;
    logic                bvalid;
    logic                bready;
    logic [3:0]          bid;
    logic [1:0]          bresp;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
               awlock, awcache, awprot, awqos,
               wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bid, bresp
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
               awlock, awcache, awprot, awqos,
               wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/ivs_dma_wr_inf.sv
// ---------------------------------------------------------------------------
// ivs_dma_wr_inf -- three-port DMA write arbiter onto one AXI write channel.
// One burst outstanding: IDLE -> ADDR -> DATA -> RESP -> IDLE.
// Ports are granted round-robin, starting after the last completed port.
//
// Ports:
//   aclk, arst_n       clock, synchronous active-low reset
//   bus (master)       AW/W/B channel (see ivs_dma_wr_inf_if)
//   dwN_req            port N burst request, held until dwN_ack
//   dwN_base/dwN_len   port N burst address / beats-1
//   dwN_wdata          port N current data word
//   dwN_rd             pop strobe, same cycle as the accepted beat
//   dwN_ack            one-cycle pulse after the B handshake
//   dwN_err            pulse with dwN_ack on SLVERR/DECERR
//
// Build option: IVS_DMA_WR_BRESP_CHK_EN enables bresp checking on dwN_err;
// without it dwN_err is always 0 and bresp is ignored.
// ---------------------------------------------------------------------------
module ivs_dma_wr_inf #(
    parameter int BDWD  = 128,
    parameter int NPORT = 3
) (
    input  logic              aclk,
    input  logic              arst_n,
    ivs_dma_wr_inf_if.master  bus,

    input  logic              dw0_req,
    input  logic [31:0]       dw0_base,
    input  logic [5:0]        dw0_len,
    input  logic [BDWD-1:0]   dw0_wdata,
    output logic              dw0_rd,
    output logic              dw0_ack,
    output logic              dw0_err,

    input  logic              dw1_req,
    input  logic [31:0]       dw1_base,
    input  logic [5:0]        dw1_len,
    input  logic [BDWD-1:0]   dw1_wdata,
    output logic              dw1_rd,
    output logic              dw1_ack,
    output logic              dw1_err,

    input  logic              dw2_req,
    input  logic [31:0]       dw2_base,
    input  logic [5:0]        dw2_len,
    input  logic [BDWD-1:0]   dw2_wdata,
    output logic              dw2_rd,
    output logic              dw2_ack,
    output logic              dw2_err
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t             state;
    logic [1:0]         gnt_q;
    logic [1:0]         rr_last;
    logic [31:0]        base_q;
    logic [5:0]         len_q;
    logic [5:0]         beat_cnt;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic [NPORT-1:0]   ack_q;
    logic [NPORT-1:0]   err_q;

    logic [NPORT-1:0]   req_m;
    logic [NPORT-1:0]   gnt_oh;
    logic [NPORT-1:0]   rd_v;
    logic [1:0]         nxt_gnt;
    logic [31:0]        nxt_base;
    logic [5:0]         nxt_len;
    logic [BDWD-1:0]    wdata_mux;
    logic               bresp_bad;
    logic               unused_bresp;

    // A port still sees its own req high in the cycle its ack pulses; mask it
    // so the finished burst is not granted a second time.
    assign req_m  = {dw2_req, dw1_req, dw0_req} & ~ack_q;
    assign gnt_oh = NPORT'(1) << gnt_q;

    // Round-robin: priority starts at the port after rr_last.
    always_comb begin
        nxt_gnt = 2'd0;
        case (rr_last)
            2'd0:    nxt_gnt = req_m[1] ? 2'd1 : (req_m[2] ? 2'd2 : 2'd0);
            2'd1:    nxt_gnt = req_m[2] ? 2'd2 : (req_m[0] ? 2'd0 : 2'd1);
            default: nxt_gnt = req_m[0] ? 2'd0 : (req_m[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        nxt_base = dw0_base;
        nxt_len  = dw0_len;
        case (nxt_gnt)
            2'd1:    begin nxt_base = dw1_base; nxt_len = dw1_len; end
            2'd2:    begin nxt_base = dw2_base; nxt_len = dw2_len; end
            default: begin nxt_base = dw0_base; nxt_len = dw0_len; end
        endcase
    end

    // Data comes straight from the granted port; the port only advances after
    // dwN_rd, so wdata stays put while wready is low.
    always_comb begin
        case (gnt_q)
            2'd1:    wdata_mux = dw1_wdata;
            2'd2:    wdata_mux = dw2_wdata;
            default: wdata_mux = dw0_wdata;
        endcase
    end

`ifdef IVS_DMA_WR_BRESP_CHK_EN
    // SLVERR (10) and DECERR (11) both have bit 1 set.
    assign bresp_bad = bus.bresp[1];
`else
    assign bresp_bad = 1'b0;
`endif
    assign unused_bresp = ^bus.bresp;

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state     <= S_IDLE;
            gnt_q     <= 2'd0;
            rr_last   <= 2'd2;
            base_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state)
                S_IDLE: begin
                    if (|req_m) begin
                        gnt_q     <= nxt_gnt;
                        base_q    <= nxt_base;
                        len_q     <= nxt_len;
                        beat_cnt  <= '0;
                        awvalid_q <= 1'b1;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.wready) begin
                        if (beat_cnt == len_q) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 6'd1;
                        end
                    end
                end
                S_RESP: begin
                    // Responses for other IDs are drained (bready stays high).
                    if (bus.bvalid && bus.bid == {2'b00, gnt_q}) begin
                        bready_q <= 1'b0;
                        ack_q    <= gnt_oh;
                        err_q    <= bresp_bad ? gnt_oh : '0;
                        rr_last  <= gnt_q;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.awvalid = awvalid_q;
    assign bus.awid    = {2'b00, gnt_q};
    assign bus.awaddr  = base_q;
    assign bus.awlen   = len_q;
    assign bus.awsize  = 3'b100;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 1'b0;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awqos   = 4'd0;
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = wdata_mux;
    assign bus.wstrb   = '1;
    assign bus.wlast   = wvalid_q && (beat_cnt == len_q);
    assign bus.bready  = bready_q;

    assign rd_v = {NPORT{wvalid_q & bus.wready}} & gnt_oh;

    assign dw0_rd  = rd_v[0];
    assign dw1_rd  = rd_v[1];
    assign dw2_rd  = rd_v[2];
    assign dw0_ack = ack_q[0];
    assign dw1_ack = ack_q[1];
    assign dw2_ack = ack_q[2];
    assign dw0_err = err_q[0];
    assign dw1_err = err_q[1];
    assign dw2_err = err_q[2];

endmodule

// File: tb/tb_ivs_dma_wr_inf.sv
// ---------------------------------------------------------------------------
// tb_ivs_dma_wr_inf -- directed bench for ivs_dma_wr_inf. The bench plays the
// three write ports and the AXI slave; expected words are computed from the
// beat index while the port model advances only on dwN_rd.
// ---------------------------------------------------------------------------
module tb_ivs_dma_wr_inf;
    localparam int BDWD = 128;
`ifdef IVS_DMA_WR_BRESP_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic arst_n;

    ivs_dma_wr_inf_if #(.BDWD(BDWD)) bus ();

    logic [2:0]       req;
    logic [31:0]      base [3];
    logic [5:0]       len  [3];
    int               pcnt [3];
    logic [BDWD-1:0]  pdata [3];
    logic [2:0]       rd, ack, err;

    int n_chk = 0;
    int n_err = 0;

    int          g_id, g_len, g_beats, g_rd, g_data_err, g_last_err, g_rd_err, g_stab_err;
    logic [31:0] g_addr;
    logic [2:0]  g_ack, g_ack2, g_err;

    function automatic logic [BDWD-1:0] exp_word(input int p, input int k);
        return {4{8'(p + 1), 24'(k)}};
    endfunction

    assign pdata[0] = exp_word(0, pcnt[0]);
    assign pdata[1] = exp_word(1, pcnt[1]);
    assign pdata[2] = exp_word(2, pcnt[2]);

    ivs_dma_wr_inf #(.BDWD(BDWD), .NPORT(3)) dut (
        .aclk(aclk), .arst_n(arst_n), .bus(bus),
        .dw0_req(req[0]), .dw0_base(base[0]), .dw0_len(len[0]), .dw0_wdata(pdata[0]),
        .dw0_rd(rd[0]), .dw0_ack(ack[0]), .dw0_err(err[0]),
        .dw1_req(req[1]), .dw1_base(base[1]), .dw1_len(len[1]), .dw1_wdata(pdata[1]),
        .dw1_rd(rd[1]), .dw1_ack(ack[1]), .dw1_err(err[1]),
        .dw2_req(req[2]), .dw2_base(base[2]), .dw2_len(len[2]), .dw2_wdata(pdata[2]),
        .dw2_rd(rd[2]), .dw2_ack(ack[2]), .dw2_err(err[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation point: 1 time unit after the falling edge.
    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    // Plays the slave side for one burst and records what was seen.
    task automatic serve(input int aw_wait, input bit wtog, input logic [1:0] resp, input bit bad_bid);
        int t;
        int cyc;
        bit done;
        logic [2:0] rd_s;
        g_id = -1; g_len = 0; g_beats = 0; g_rd = 0; g_data_err = 0; g_last_err = 0;
        g_rd_err = 0; g_stab_err = 0; g_ack = 0; g_ack2 = 0; g_err = 0; g_addr = 0;
        t = 0;
        while (!bus.awvalid && t < 50) begin tick(); t++; end
        if (!bus.awvalid) begin chk("aw_timeout", 1, 0); return; end
        if (bus.wvalid) g_stab_err++;
        g_id   = int'(bus.awid);
        g_addr = bus.awaddr;
        g_len  = int'(bus.awlen);
        for (int i = 0; i < aw_wait; i++) begin
            tick();
            if (!bus.awvalid || bus.awaddr !== g_addr || bus.wvalid) g_stab_err++;
        end
        bus.awready = 1'b1;
        tick();
        bus.awready = 1'b0;
        if (bus.awvalid) g_stab_err++;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            bus.wready = (!wtog || (cyc % 2) == 0);
            #1;
            rd_s = rd;
            if (!bus.wvalid) g_stab_err++;
            else begin
                if (bus.wdata !== exp_word(g_id, g_beats)) g_data_err++;
                if (bus.wlast !== (g_beats == g_len)) g_last_err++;
                if (bus.wready) begin
                    if (rd_s !== (3'b001 << g_id)) g_rd_err++;
                    else g_rd++;
                    g_beats++;
                    done = bus.wlast;
                end else if (rd_s !== 3'b000) g_rd_err++;
            end
            tick();
            for (int i = 0; i < 3; i++) if (rd_s[i]) pcnt[i]++;
            cyc++;
        end
        bus.wready = 1'b0;
        if (!done) begin chk("w_timeout", 1, 0); return; end
        if (bus.wvalid || !bus.bready) g_stab_err++;
        if (bad_bid) begin
            bus.bvalid = 1'b1; bus.bid = 4'((g_id + 1) % 3); bus.bresp = 2'b00;
            tick();
            bus.bvalid = 1'b0;
            if (ack !== 3'b000 || !bus.bready) g_stab_err++;
        end
        bus.bvalid = 1'b1; bus.bid = 4'(g_id); bus.bresp = resp;
        tick();
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        g_ack = ack;
        g_err = err;
        tick();
        g_ack2 = ack;
        req[g_id] = 1'b0;
    endtask

    task automatic check_burst(input string tag, input int id, input logic [31:0] addr,
                               input int l, input bit e);
        chk({tag, ".awid"},   g_id, id);
        chk({tag, ".awaddr"}, g_addr, addr);
        chk({tag, ".awlen"},  g_len, l);
        chk({tag, ".beats"},  g_beats, l + 1);
        chk({tag, ".rd_cnt"}, g_rd, l + 1);
        chk({tag, ".wdata"},  g_data_err, 0);
        chk({tag, ".wlast"},  g_last_err, 0);
        chk({tag, ".rd_err"}, g_rd_err, 0);
        chk({tag, ".hold"},   g_stab_err, 0);
        chk({tag, ".ack"},    g_ack, 3'b001 << id);
        chk({tag, ".ack_1cy"}, g_ack2, 0);
        chk({tag, ".err"},    g_err, e ? (3'b001 << id) : 3'b000);
    endtask

    task automatic clr_ports();
        for (int i = 0; i < 3; i++) pcnt[i] = 0;
    endtask

    initial begin
        int seen;
        arst_n = 1'b0;
        req = 3'b000;
        for (int i = 0; i < 3; i++) begin base[i] = 0; len[i] = 0; pcnt[i] = 0; end
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.bid = 4'd0; bus.bresp = 2'b00;
        repeat (3) tick();
        chk("rst.awvalid", bus.awvalid, 0);
        chk("rst.wvalid",  bus.wvalid, 0);
        chk("rst.bready",  bus.bready, 0);
        chk("rst.ack",     ack, 0);
        chk("rst.err",     err, 0);
        chk("rst.awsize",  {bus.awsize, bus.awburst}, {3'b100, 2'b01});
        arst_n = 1'b1;
        tick();

        // All three ports together, single beats: 0,1,2 then 0,1,2 again.
        for (int r = 0; r < 2; r++) begin
            clr_ports();
            for (int i = 0; i < 3; i++) begin base[i] = 32'h100 * (i + 1) + r; len[i] = 6'd0; end
            req = 3'b111;
            tick();
            chk("rr.latency", bus.awvalid, 1);
            for (int i = 0; i < 3; i++) begin
                serve(0, 1'b0, 2'b00, 1'b0);
                check_burst($sformatf("rr%0d_%0d", r, i), i, 32'h100 * (i + 1) + r, 0, 1'b0);
            end
        end

        // Port 0 alone, len 3, always ready; no second grant from the stale req.
        clr_ports();
        base[0] = 32'h1000; len[0] = 6'd3; req[0] = 1'b1;
        serve(0, 1'b0, 2'b00, 1'b0);
        check_burst("p0len3", 0, 32'h1000, 3, 1'b0);
        chk("p0len3.no_regrant", bus.awvalid, 0);

        // Port 2, len 7, wready toggling.
        clr_ports();
        base[2] = 32'h2000; len[2] = 6'd7; req[2] = 1'b1;
        serve(0, 1'b1, 2'b00, 1'b0);
        check_burst("wtog", 2, 32'h2000, 7, 1'b0);

        // Port 1, awready held low 5 cycles.
        clr_ports();
        base[1] = 32'h1234_5670; len[1] = 6'd1; req[1] = 1'b1;
        serve(5, 1'b0, 2'b00, 1'b0);
        check_burst("awstall", 1, 32'h1234_5670, 1, 1'b0);

        // Port 1, SLVERR response preceded by a foreign-ID response.
        clr_ports();
        base[1] = 32'h8000; len[1] = 6'd2; req[1] = 1'b1;
        serve(0, 1'b0, 2'b10, 1'b1);
        check_burst("slverr", 1, 32'h8000, 2, ERR_EN);

        // Port 0, len 63: 64 beats with no counter wrap.
        clr_ports();
        base[0] = 32'hFFFF_0000; len[0] = 6'd63; req[0] = 1'b1;
        serve(0, 1'b0, 2'b00, 1'b0);
        check_burst("len63", 0, 32'hFFFF_0000, 63, 1'b0);

        // Last grant was port 0: ports 0 and 2 together go 2 then 0.
        clr_ports();
        base[0] = 32'hA000; len[0] = 6'd0; base[2] = 32'hC000; len[2] = 6'd1;
        req[0] = 1'b1; req[2] = 1'b1;
        serve(0, 1'b0, 2'b00, 1'b0);
        check_burst("rr02a", 2, 32'hC000, 1, 1'b0);
        serve(0, 1'b0, 2'b00, 1'b0);
        check_burst("rr02b", 0, 32'hA000, 0, 1'b0);

        // Reset in the middle of a len-5 burst.
        clr_ports();
        base[0] = 32'h3000; len[0] = 6'd5; req[0] = 1'b1;
        tick();
        bus.awready = 1'b1;
        tick();
        bus.awready = 1'b0;
        bus.wready  = 1'b1;
        tick();
        tick();
        arst_n = 1'b0;
        req[0] = 1'b0;
        tick();
        bus.wready = 1'b0;
        chk("midrst.valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b000);
        chk("midrst.ack", ack, 0);
        arst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack !== 3'b000 || bus.awvalid || bus.wvalid) seen++;
        end
        chk("midrst.quiet", seen, 0);
        clr_ports();
        base[0] = 32'h4000; len[0] = 6'd5; req[0] = 1'b1;
        serve(0, 1'b0, 2'b00, 1'b0);
        check_burst("postrst", 0, 32'h4000, 5, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ivs_dma_wr_inf.md
IVS_DMA_WR_INF -- requirements
Module: ivs_dma_wr_inf

Interface
REQ-001 SHALL have parameter BDWD, default 128, meaning bus data width in bits.
REQ-002 SHALL have parameter NPORT, default 3, meaning number of write ports; fixed at 3.
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 arst_n  in  1  reset, synchronous, active-low.
REQ-005 awvalid/awready  out/in  1/1  write-address handshake.
REQ-006 awid  out  4  write ID, equals the granted port index (0..2).
REQ-007 awaddr  out  32  burst base address.
REQ-008 awlen  out  6  burst beats minus 1.
REQ-009 awsize/awburst  out  3/2  constant 3'b100 / 2'b01.
REQ-010 awlock/awcache/awprot/awqos  out  1/4/3/4  constant 0.
REQ-011 wvalid/wready  out/in  1/1  write-data handshake.
REQ-012 wdata/wstrb/wlast  out  BDWD/BDWD/8/1  data, all-ones strobe, last beat.
REQ-013 bvalid/bready  in/out  1/1  write-response handshake.
REQ-014 bid/bresp  in  4/2  response ID and status.
REQ-015 dwN_req  in  1  port N (N=0..2) requests a burst; held until dwN_ack.
REQ-016 dwN_base/dwN_len  in  32/6  port N address and beats minus 1; stable while dwN_req is high.
REQ-017 dwN_wdata  in  BDWD  port N next data word, valid whenever dwN_req is high.
REQ-018 dwN_rd  out  1  pop strobe: port N advances dwN_wdata next cycle.
REQ-019 dwN_ack  out  1  one-cycle pulse on burst completion (B received).
REQ-020 dwN_err  out  1  one-cycle pulse with dwN_ack when bresp != 2'b00 (see Configuration).

Function
REQ-021 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE; one burst outstanding.
REQ-022 IDLE: with any dwN_req high, SHALL grant round-robin starting after the last granted port, latch base/len/index, and enter ADDR next cycle.
REQ-023 ADDR: awvalid=1 with latched fields; on awvalid&awready SHALL enter DATA.
REQ-024 DATA: wvalid=1, wdata=granted dwN_wdata; each wvalid&wready beat SHALL pulse the granted dwN_rd in the same cycle and increment the 6-bit beat counter.
REQ-025 wlast SHALL be 1 when beat count == latched len; on that accepted beat SHALL enter RESP.
REQ-026 RESP: bready=1; on bvalid with bid == latched index SHALL pulse dwN_ack, return to IDLE, and update the round-robin pointer.
REQ-027 bvalid with mismatched bid SHALL be consumed and ignored; the FSM remains in RESP.
REQ-028 len=0 SHALL produce a single beat with wlast=1.
REQ-029 len=63 SHALL produce 64 beats; the counter SHALL NOT wrap before wlast.
REQ-030 Requests deasserted before grant SHALL be dropped; after grant, request changes SHALL be ignored until ack.
REQ-031 awvalid and wvalid SHALL remain asserted until their respective ready; outputs SHALL not change while valid is high and ready is low.
REQ-032 Minimum latency is req to awvalid = 1 cycle, and ack = 1 cycle after the bvalid handshake.

Reset
REQ-033 When arst_n is low at a clock edge: FSM=IDLE, awvalid=wvalid=bready=0, dwN_rd=dwN_ack=dwN_err=0, counter=0, round-robin pointer=port 2 (port 0 wins first).
REQ-034 Reset mid-burst SHALL abort immediately without completing the burst or issuing ack.

Configuration
REQ-035 Macro IVS_DMA_WR_BRESP_CHK_EN: when defined, dwN_err SHALL pulse with dwN_ack if bresp is SLVERR or DECERR; when undefined, dwN_err SHALL be tied 0 and bresp ignored.

Verification
REQ-036 dw0_req only, base=0x1000, len=3, always-ready bus -> awaddr=0x1000, awlen=3, 4 beats, wlast on 4th, dw0_rd 4 pulses, one dw0_ack.
REQ-037 All three req together, len=0 each -> awid order 0,1,2; then re-raise all -> order continues 0,1,2.
REQ-038 wready toggling 1-0-1-0, len=7 -> exactly 8 accepted beats, wdata held stable while wready=0, 8 dw_rd pulses.
REQ-039 awready held low 5 cycles -> awvalid stays 1 with awaddr stable; no wvalid before the handshake.
REQ-040 bresp=2'b10 on port 1 burst -> dw1_err=1 with dw1_ack when the macro is defined, 0 otherwise.
REQ-041 arst_n low at beat 2 of len=5 -> next cycle all valids 0, no ack; a new req completes normally.
